// File: rtl/postif_inst_buffer.sv
// postif_inst_buffer
//
// Two-entry instruction buffer between the post-IF pipeline register and ID.
// The synchronous instruction SRAM returns its word only during the post-IF
// cycle. This block captures that word with its PC and fetch exception code,
// and holds it while ID is stalled. Entries go to ID in order under a
// valid/stall handshake.
//
// Ports:
//   clock_i                  rising-edge clock
//   reset_i                  asynchronous active-high reset
//   postif_pc_i              PC of the post-IF word
//   postif_exception_type_i  fetch exception code, 0 = none
//   postif_inst_ren_i        an SRAM read was issued for this PC
//   postif_inst_valid_i      the post-IF slot is live (not squashed)
//   inst_rdata_i             SRAM read data, valid in the post-IF cycle
//   exception_i              pipeline flush
//   id_stall_i               ID cannot take the head entry this cycle
//   id_pc_o / id_inst_o / id_exception_type_o  head entry, or 0 when empty
//   id_valid_o               head entry present
//   fetch_stall_o            combinational request to freeze IF/post-IF
//   overflow_o               sticky flag: a word arrived while the buffer was full

module postif_inst_buffer (
  input  logic        clock_i,
  input  logic        reset_i,
  input  logic [31:0] postif_pc_i,
  input  logic [31:0] postif_exception_type_i,
  input  logic        postif_inst_ren_i,
  input  logic        postif_inst_valid_i,
  input  logic [31:0] inst_rdata_i,
  input  logic        exception_i,
  input  logic        id_stall_i,
  output logic [31:0] id_pc_o,
  output logic [31:0] id_inst_o,
  output logic [31:0] id_exception_type_o,
  output logic        id_valid_o,
  output logic        fetch_stall_o,
  output logic        overflow_o
);

  logic [1:0]  count_reg, count_next;
  logic [31:0] head_pc_reg, head_pc_next;
  logic [31:0] head_inst_reg, head_inst_next;
  logic [31:0] head_exc_reg, head_exc_next;
  logic [31:0] tail_pc_reg, tail_pc_next;
  logic [31:0] tail_inst_reg, tail_inst_next;
  logic [31:0] tail_exc_reg, tail_exc_next;
  logic        overflow_reg, overflow_next;

  logic        enq;
  logic        deq;
  logic [31:0] new_inst;

  // A fetch that only carries an exception (no SRAM read) still enqueues,
  // as a NOP, so that the exception reaches ID in program order.
  assign enq      = postif_inst_valid_i &
                    (postif_inst_ren_i | (postif_exception_type_i != 32'h0));
  assign new_inst = postif_inst_ren_i ? inst_rdata_i : 32'h0;
  assign deq      = id_valid_o & ~id_stall_i;

  // The stall is raised one word early. The word already in post-IF then
  // always has a free slot on the next edge.
  assign fetch_stall_o = (count_reg == 2'd2) |
                         ((count_reg == 2'd1) & enq & ~deq);

  always_comb begin
    count_next     = count_reg;
    head_pc_next   = head_pc_reg;
    head_inst_next = head_inst_reg;
    head_exc_next  = head_exc_reg;
    tail_pc_next   = tail_pc_reg;
    tail_inst_next = tail_inst_reg;
    tail_exc_next  = tail_exc_reg;
    overflow_next  = overflow_reg;

    if (exception_i) begin
      count_next = 2'd0;
    end else begin
      case (count_reg)
        2'd0: begin
          if (enq) begin
            head_pc_next   = postif_pc_i;
            head_inst_next = new_inst;
            head_exc_next  = postif_exception_type_i;
            count_next     = 2'd1;
          end
        end
        2'd1: begin
          if (enq && deq) begin
            head_pc_next   = postif_pc_i;
            head_inst_next = new_inst;
            head_exc_next  = postif_exception_type_i;
          end else if (enq) begin
            tail_pc_next   = postif_pc_i;
            tail_inst_next = new_inst;
            tail_exc_next  = postif_exception_type_i;
            count_next     = 2'd2;
          end else if (deq) begin
            count_next = 2'd0;
          end
        end
        default: begin
          if (deq) begin
            head_pc_next   = tail_pc_reg;
            head_inst_next = tail_inst_reg;
            head_exc_next  = tail_exc_reg;
            if (enq) begin
              tail_pc_next   = postif_pc_i;
              tail_inst_next = new_inst;
              tail_exc_next  = postif_exception_type_i;
            end else begin
              count_next = 2'd1;
            end
          end else if (enq) begin
            // The buffer is full and the word is dropped. This means IF
            // ignored fetch_stall_o.
            overflow_next = 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      count_reg     <= 2'd0;
      head_pc_reg   <= 32'h0;
      head_inst_reg <= 32'h0;
      head_exc_reg  <= 32'h0;
      tail_pc_reg   <= 32'h0;
      tail_inst_reg <= 32'h0;
      tail_exc_reg  <= 32'h0;
      overflow_reg  <= 1'b0;
    end else begin
      count_reg     <= count_next;
      head_pc_reg   <= head_pc_next;
      head_inst_reg <= head_inst_next;
      head_exc_reg  <= head_exc_next;
      tail_pc_reg   <= tail_pc_next;
      tail_inst_reg <= tail_inst_next;
      tail_exc_reg  <= tail_exc_next;
      overflow_reg  <= overflow_next;
    end
  end

  // When the buffer is empty, the head registers may still hold a dequeued
  // or flushed word. That word is masked here, so it never reaches ID.
  assign id_valid_o          = (count_reg != 2'd0);
  assign id_pc_o             = id_valid_o ? head_pc_reg   : 32'h0;
  assign id_inst_o           = id_valid_o ? head_inst_reg : 32'h0;
  assign id_exception_type_o = id_valid_o ? head_exc_reg  : 32'h0;
  assign overflow_o          = overflow_reg;

endmodule

// File: tb/tb_postif_inst_buffer.sv
module tb_postif_inst_buffer;

  logic        clock_i = 1'b0;
  logic        reset_i;
  logic [31:0] postif_pc_i;
  logic [31:0] postif_exception_type_i;
  logic        postif_inst_ren_i;
  logic        postif_inst_valid_i;
  logic [31:0] inst_rdata_i;
  logic        exception_i;
  logic        id_stall_i;
  logic [31:0] id_pc_o;
  logic [31:0] id_inst_o;
  logic [31:0] id_exception_type_o;
  logic        id_valid_o;
  logic        fetch_stall_o;
  logic        overflow_o;

  postif_inst_buffer dut (
    .clock_i                 (clock_i),
    .reset_i                 (reset_i),
    .postif_pc_i             (postif_pc_i),
    .postif_exception_type_i (postif_exception_type_i),
    .postif_inst_ren_i       (postif_inst_ren_i),
    .postif_inst_valid_i     (postif_inst_valid_i),
    .inst_rdata_i            (inst_rdata_i),
    .exception_i             (exception_i),
    .id_stall_i              (id_stall_i),
    .id_pc_o                 (id_pc_o),
    .id_inst_o               (id_inst_o),
    .id_exception_type_o     (id_exception_type_o),
    .id_valid_o              (id_valid_o),
    .fetch_stall_o           (fetch_stall_o),
    .overflow_o              (overflow_o)
  );

  always #5 clock_i = ~clock_i;

  typedef struct {
    logic        valid;
    logic        ren;
    logic [31:0] pc;
    logic [31:0] inst;
    logic [31:0] exc;
    logic        flush;
    logic        stall;
    int          exp_stall;  // -1: take the expected stall from the model
  } vec_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [31:0] exc;
  } entry_t;

  entry_t sb_q[$];
  logic   model_ovf;
  int     checks   = 0;
  int     failures = 0;
  vec_t   tbl[40];
  int     ntbl     = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic add(input logic v, input logic r, input logic [31:0] pc,
                     input logic [31:0] inst, input logic [31:0] exc,
                     input logic fl, input logic st, input int es);
    tbl[ntbl] = '{v, r, pc, inst, exc, fl, st, es};
    ntbl++;
  endtask

  // Compare the registered state the DUT shows against the scoreboard head.
  task automatic check_state();
    chk("id_valid", {31'h0, id_valid_o}, {31'h0, sb_q.size() != 0});
    if (sb_q.size() != 0) begin
      chk("id_pc", id_pc_o, sb_q[0].pc);
      chk("id_inst", id_inst_o, sb_q[0].inst);
      chk("id_exc", id_exception_type_o, sb_q[0].exc);
    end else begin
      chk("id_pc_zero", id_pc_o, 32'h0);
      chk("id_inst_zero", id_inst_o, 32'h0);
      chk("id_exc_zero", id_exception_type_o, 32'h0);
    end
    chk("overflow", {31'h0, overflow_o}, {31'h0, model_ovf});
  endtask

  // One clock cycle. It is entered just after a falling edge and exits just
  // after the next falling edge.
  task automatic step(input vec_t v);
    logic   m_enq, m_deq, m_stall;
    int     sz;
    entry_t e;
    check_state();
    postif_inst_valid_i     = v.valid;
    postif_inst_ren_i       = v.ren;
    postif_pc_i             = v.pc;
    inst_rdata_i            = v.inst;
    postif_exception_type_i = v.exc;
    exception_i             = v.flush;
    id_stall_i              = v.stall;
    #1;
    sz      = sb_q.size();
    m_enq   = v.valid && (v.ren || v.exc != 32'h0);
    m_deq   = (sz != 0) && !v.stall;
    m_stall = (sz == 2) || (sz == 1 && m_enq && !m_deq);
    if (v.exp_stall >= 0)
      chk("fetch_stall_tbl", {31'h0, fetch_stall_o}, v.exp_stall);
    else
      chk("fetch_stall", {31'h0, fetch_stall_o}, {31'h0, m_stall});
    @(posedge clock_i);
    if (v.flush) begin
      sb_q.delete();
    end else begin
      if (m_deq) begin
        e = sb_q.pop_front();
        $display("deq pc=%08h inst=%08h exc=%08h", e.pc, e.inst, e.exc);
      end
      if (m_enq) begin
        if (sz == 2 && !m_deq) begin
          model_ovf = 1'b1;
        end else begin
          e.pc   = v.pc;
          e.inst = v.ren ? v.inst : 32'h0;
          e.exc  = v.exc;
          sb_q.push_back(e);
        end
      end
    end
    @(negedge clock_i);
  endtask

  task automatic fetch(input logic [31:0] pc, input logic [31:0] inst, input logic st);
    vec_t v;
    v = '{1'b1, 1'b1, pc, inst, 32'h0, 1'b0, st, -1};
    step(v);
  endtask

  task automatic idle(input logic st);
    vec_t v;
    v = '{1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, st, -1};
    step(v);
  endtask

  initial begin
    vec_t v;
    model_ovf               = 1'b0;
    reset_i                 = 1'b1;
    postif_pc_i             = '0;
    postif_exception_type_i = '0;
    postif_inst_ren_i       = 1'b0;
    postif_inst_valid_i     = 1'b0;
    inst_rdata_i            = '0;
    exception_i             = 1'b0;
    id_stall_i              = 1'b0;
    repeat (2) @(negedge clock_i);
    chk("reset_fetch_stall", {31'h0, fetch_stall_o}, 32'h0);
    reset_i = 1'b0;

    // Streaming: 8 back-to-back fetches, then the pipeline drains.
    for (int k = 0; k < 8; k++)
      add(1, 1, 32'hBFC00000 + 32'(4 * k), 32'h24080000 + 32'(k), 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0);
    // Stall fill: the second enqueue raises the stall, then the buffer drains.
    add(1, 1, 32'hBFC00000, 32'h11111111, 0, 0, 1, 0);
    add(1, 1, 32'hBFC00004, 32'h22222222, 0, 0, 1, 1);
    add(0, 0, 0, 0, 0, 0, 1, 1);
    add(0, 0, 0, 0, 0, 0, 0, 1);
    add(0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0);
    // A squashed slot with live-looking data must not enqueue.
    add(0, 1, 32'hBFC00008, 32'hDEADBEEF, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0);
    // An exception-only fetch is enqueued as a NOP.
    add(1, 0, 32'h00000001, 32'h55555555, 32'h4, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0);

    @(negedge clock_i);
    for (int i = 0; i < ntbl; i++) step(tbl[i]);

    // Flush while full, with a simultaneous enqueue that must be discarded.
    fetch(32'hBFC00100, 32'hAAAA0001, 1'b1);
    fetch(32'hBFC00104, 32'hAAAA0002, 1'b1);
    v = '{1'b1, 1'b1, 32'hBFC00108, 32'hAAAA0003, 32'h0, 1'b1, 1'b1, 1};
    step(v);
    idle(1'b0);
    fetch(32'hBFC00380, 32'h3C1A0000, 1'b0);
    idle(1'b0);
    idle(1'b0);

    // Overflow: an enqueue at count 2 while ID stalls.
    fetch(32'hBFC00200, 32'hBBBB0001, 1'b1);
    fetch(32'hBFC00204, 32'hBBBB0002, 1'b1);
    fetch(32'hBFC00208, 32'hBBBB0003, 1'b1);
    idle(1'b1);
    idle(1'b0);
    idle(1'b0);
    idle(1'b0);

    // Asynchronous reset in the middle of the cycle, with the buffer full.
    fetch(32'hBFC00300, 32'hCCCC0001, 1'b1);
    fetch(32'hBFC00304, 32'hCCCC0002, 1'b1);
    chk("pre_reset_valid", {31'h0, id_valid_o}, 32'h1);
    #2 reset_i = 1'b1;
    #1;
    chk("async_rst_valid", {31'h0, id_valid_o}, 32'h0);
    chk("async_rst_pc", id_pc_o, 32'h0);
    chk("async_rst_inst", id_inst_o, 32'h0);
    chk("async_rst_exc", id_exception_type_o, 32'h0);
    chk("async_rst_ovf", {31'h0, overflow_o}, 32'h0);
    chk("async_rst_stall", {31'h0, fetch_stall_o}, 32'h0);
    sb_q.delete();
    model_ovf = 1'b0;
    @(negedge clock_i);
    reset_i = 1'b0;
    fetch(32'hBFC00000, 32'h24080001, 1'b0);
    idle(1'b0);
    idle(1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
